wb_ram_pipe: RTL

WB_RAM_PIPE -- requirements
Module: wb_ram_pipe

---
 rtl/wb_pkg.sv | 13 +
 rtl/spram_be.sv | 27 ++
 rtl/wb_ram_pipe.sv | 69 ++++++
 3 files changed

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone RAM defaults, termination flag type and latency check
package wb_pkg;
  localparam int WB_DATA_WIDTH = 16;
  localparam int WB_ADDR_WIDTH = 13;
  typedef struct packed {
    logic vld;
    logic err;
    logic rd;
  } wb_flags_t;
  function automatic bit wb_lat_ok(input int lat);
    return lat == 1 || lat == 2;
  endfunction
endpackage

// File: rtl/spram_be.sv
// spram_be: byte-enabled single-port RAM with registered read data and no reset
module spram_be #(
  parameter int DW    = 16,
  parameter int AW    = 13,
  parameter int DEPTH = 2 ** AW
) (
  input  logic            clk,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [DW/8-1:0] sel_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  output logic [DW-1:0]   rdata_o
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk)
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < DW / 8; i++)
          if (sel_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/wb_ram_pipe.sv
// wb_ram_pipe: pipelined Wishbone RAM slave with fixed 1- or 2-cycle termination latency
module wb_ram_pipe
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wb_cyc,
  input  logic                    wb_stb,
  input  logic                    wb_we,
  input  logic [DATA_WIDTH/8-1:0] wb_sel,
  input  logic [ADDR_WIDTH-1:0]   wb_adr,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack,
  output logic                    wb_err,
  output logic                    wb_stall
);
  localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  if (!wb_lat_ok(RD_LATENCY) || DATA_WIDTH % 8 != 0 || DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_bad
    $error("wb_ram_pipe: illegal RD_LATENCY, DATA_WIDTH or DEPTH");
  end
  wb_flags_t [RD_LATENCY-1:0] pipe_q, pipe_d;
  wb_flags_t req, last;
  logic acc, in_range;
  logic [DATA_WIDTH-1:0] rdata;
  assign wb_stall = 1'b0;
  assign acc      = wb_cyc & wb_stb;
  assign in_range = {1'b0, wb_adr} < DEPTH_L;
  assign req      = {acc, acc & ~in_range, acc & ~wb_we & in_range};
  assign last     = pipe_q[RD_LATENCY-1];
  assign wb_ack   = last.vld & ~last.err;
  assign wb_err   = last.vld & last.err;
  // Dropping wb_cyc flushes every pending termination in one edge
  always_comb begin
    pipe_d = '0;
    if (wb_cyc) begin
      pipe_d[0] = req;
      for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) pipe_q <= '0;
    else pipe_q <= pipe_d;
  spram_be #(.DW(DATA_WIDTH), .AW(IW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .en_i    (acc & in_range & ~rst),
    .we_i    (wb_we),
    .sel_i   (wb_sel),
    .addr_i  (wb_adr[IW-1:0]),
    .wdata_i (wb_dat_i),
    .rdata_o (rdata)
  );
  if (RD_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] dat_q, dat_d;
    assign dat_d = (wb_cyc & pipe_q[0].rd) ? rdata : '0;
    always_ff @(posedge clk or posedge rst)
      if (rst) dat_q <= '0;
      else dat_q <= dat_d;
    assign wb_dat_o = dat_q;
  end else begin : g_lat1
    assign wb_dat_o = last.rd ? rdata : '0;
  end
endmodule
